// File: rtl/fifo_drain_reader_pkg.sv
// Shared definitions for the FIFO drain reader: default data width and the
// occupancy encoding of its two-entry output buffer.
package fifo_drain_reader_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // The encoding doubles as the occupancy count presented to the consumer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL2 = 2'd2
    } drainState_e;

    function automatic drainState_e advanceState(input drainState_e cur);
        case (cur)
            ST_EMPTY: return ST_ONE;
            ST_ONE:   return ST_FULL2;
            default:  return cur;
        endcase
    endfunction

    function automatic drainState_e retreatState(input drainState_e cur);
        case (cur)
            ST_FULL2: return ST_ONE;
            ST_ONE:   return ST_EMPTY;
            default:  return cur;
        endcase
    endfunction

endpackage

// File: rtl/fifo_drain_reader_if.sv
// Handshake bundle between the upstream FIFO, the drain reader and its consumer.
interface fifo_drain_reader_if
    import fifo_drain_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_r_en;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    modport master (
        input  fifo_empty, fifo_dout, flush, out_ready,
        output fifo_r_en, out_valid, out_data, count
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, out_ready,
        input  fifo_r_en, out_valid, out_data, count
    );

endinterface

// File: rtl/fifo_drain_reader_dispatch_skid.sv
// Two-slot data store with head/tail select; occupancy is tracked by the parent,
// so this block only steers writes and exposes the oldest slot.
module dispatch_skid
    import fifo_drain_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic             r_head;
    logic             r_tail;

    // When full, push and pop target the same slot; the old value is read out
    // before the write lands, so the overwrite is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else if (i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (i_push) begin
                if (r_tail) begin
                    r_slot1 <= i_din;
                end else begin
                    r_slot0 <= i_din;
                end
                r_tail <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    assign o_head = r_head ? r_slot1 : r_slot0;

endmodule

// File: rtl/fifo_drain_reader.sv
// Drains an asynchronous-read FIFO into a registered two-entry buffer that
// presents a valid/ready stream; flush discards everything buffered.
module fifo_drain_reader
    import fifo_drain_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    fifo_drain_reader_if.master bus
);

    drainState_e      r_state;
    drainState_e      w_nextState;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    assign w_pop = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A full buffer may still pull from the FIFO when the consumer frees a slot
    // in the same cycle.
    always_comb begin
        w_push      = 1'b0;
        w_nextState = r_state;
        w_push = !bus.fifo_empty && !bus.flush && !reset
                 && ((r_state != ST_FULL2) || w_pop);
        if (bus.flush) begin
            w_nextState = ST_EMPTY;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_nextState = advanceState(r_state);
                2'b01:   w_nextState = retreatState(r_state);
                default: w_nextState = r_state;
            endcase
        end
    end

    dispatch_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_din   (bus.fifo_dout),
        .o_head  (w_head)
    );

    assign bus.fifo_r_en = w_push;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = w_head;
    assign bus.count     = r_state;

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Randomized and directed bench for fifo_drain_reader against a queue-based
// model of the upstream FIFO and the buffered entries.
module tb_fifo_drain_reader;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;

    logic [WIDTH-1:0] srcQ[$];
    logic [WIDTH-1:0] bufQ[$];

    fifo_drain_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_drain_reader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic driveInputs(input logic flushIn, input logic readyIn);
        bus.flush      = flushIn;
        bus.out_ready  = readyIn;
        bus.fifo_empty = (srcQ.size() == 0);
        bus.fifo_dout  = (srcQ.size() == 0) ? $urandom : srcQ[0];
    endtask

    // One clock cycle: drive, check against the model, then advance the model
    // to what the coming posedge should produce.
    task automatic applyStimulus(input logic flushIn, input logic readyIn);
        logic expValid;
        logic expPop;
        logic expREn;
        @(negedge clk);
        driveInputs(flushIn, readyIn);
        #1;
        expValid = (bufQ.size() != 0);
        expPop   = expValid && readyIn;
        expREn   = (srcQ.size() != 0) && !flushIn && ((bufQ.size() < 2) || expPop);
        checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
        checkOutput("count", 32'(bus.count), 32'(bufQ.size()));
        checkOutput("fifo_r_en", 32'(bus.fifo_r_en), 32'(expREn));
        if (expValid) begin
            checkOutput("out_data", bus.out_data, bufQ[0]);
        end
        if (flushIn) begin
            bufQ.delete();
        end else begin
            if (expPop) void'(bufQ.pop_front());
            if (expREn) bufQ.push_back(srcQ[0]);
        end
        if (bus.fifo_r_en && srcQ.size() != 0) void'(srcQ.pop_front());
    endtask

    // Asserts reset between clock edges with the FIFO non-empty and checks the
    // outputs clear before any edge arrives.
    task automatic applyReset();
        reset = 1'b1;
        if (srcQ.size() == 0) srcQ.push_back($urandom);
        bus.fifo_empty = 1'b0;
        bus.fifo_dout  = srcQ[0];
        bus.out_ready  = 1'b1;
        bus.flush      = 1'b0;
        #1;
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", bus.out_data, 32'd0);
        checkOutput("rst_r_en", 32'(bus.fifo_r_en), 32'd0);
        bufQ.delete();
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] streamExp[3];
        logic [WIDTH-1:0] bpExp[3];
        int sizeBefore;

        checkCount     = 0;
        failCount      = 0;
        reset          = 1'b0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        #2;
        applyReset();

        // Streaming at one entry per cycle.
        streamExp = '{32'h11, 32'h22, 32'h33};
        srcQ = '{32'h11, 32'h22, 32'h33};
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("stream_data", bus.out_data, streamExp[i]);
            checkOutput("stream_count", 32'(bus.count), 32'd1);
        end
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);

        // Backpressure, then full buffer with simultaneous push and pop.
        bpExp = '{32'hA0, 32'hA1, 32'hA2};
        srcQ = '{32'hA0, 32'hA1, 32'hA2};
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("bp_count", 32'(bus.count), 32'd2);
        checkOutput("bp_r_en", 32'(bus.fifo_r_en), 32'd0);
        checkOutput("bp_left_in_fifo", 32'(srcQ.size()), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("bp_order", bus.out_data, bpExp[i]);
            if (i == 0) checkOutput("full_pushpop_r_en", 32'(bus.fifo_r_en), 32'd1);
            if (i == 1) checkOutput("full_pushpop_count", 32'(bus.count), 32'd2);
        end
        applyStimulus(1'b0, 1'b1);

        // Flush while full with the consumer ready.
        srcQ = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        sizeBefore = srcQ.size();
        applyStimulus(1'b1, 1'b1);
        checkOutput("flush_no_pop", 32'(srcQ.size()), 32'(sizeBefore));
        applyStimulus(1'b0, 1'b0);
        checkOutput("flush_count", 32'(bus.count), 32'd0);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);

        // Empty FIFO throughout.
        srcQ.delete();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        checkOutput("empty_r_en", 32'(bus.fifo_r_en), 32'd0);
        checkOutput("empty_valid", 32'(bus.out_valid), 32'd0);

        // Random traffic with occasional flushes and a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (srcQ.size() < 4 && $urandom_range(0, 2) != 0) srcQ.push_back($urandom);
            if (i == 200) begin
                #1;
                applyReset();
            end
            applyStimulus(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fifo_drain_reader.md
FIFO_DRAIN_READER -- requirements
Module: fifo_drain_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the data width of the drained FIFO entries.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port fifo_empty, input, 1 bit: empty flag of the upstream synchronous FIFO.
REQ-005 SHALL have port fifo_dout, input, WIDTH bits: the FIFO head entry, valid in the same cycle whenever fifo_empty=0 (asynchronous read).
REQ-006 SHALL have port fifo_r_en, output, 1 bit: pop request to the FIFO; the head advances on the next posedge.
REQ-007 SHALL have port flush, input, 1 bit: discards all buffered entries (mispredict/exception recovery).
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-009 SHALL have port out_data, output, WIDTH bits: the oldest buffered entry.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data when out_valid=1.
REQ-011 SHALL have port count, output, 2 bits: number of buffered entries, 0..2.

Function
REQ-012 SHALL hold at most 2 entries in a registered buffer with states EMPTY (0), ONE (1) and FULL2 (2).
REQ-013 SHALL define pop = out_valid AND out_ready, and push = fifo_r_en.
REQ-014 SHALL drive fifo_r_en = NOT fifo_empty AND NOT flush AND NOT reset AND (count<2 OR pop), combinationally.
REQ-015 SHALL capture fifo_dout into the buffer at the posedge where push=1; the entry is visible on out_data from the next cycle (1-cycle latency).
REQ-016 SHALL update count at each posedge as count + push - pop, with FULL2 plus push plus pop staying FULL2.
REQ-017 SHALL make push without pop advance the state EMPTY->ONE->FULL2, pop without push retreat it FULL2->ONE->EMPTY, and push with pop leave it unchanged.
REQ-018 SHALL deliver entries in strict FIFO order, with no duplication or loss, across every push/pop combination.
REQ-019 SHALL drive out_valid = (count != 0) and out_data = oldest entry, both from registers only.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL on flush=1 set count to 0 and out_valid to 0 at the next posedge, ignoring a same-cycle pop and issuing no push.
REQ-022 SHALL sustain 1 entry per cycle when fifo_empty=0 and out_ready=1 continuously.
REQ-023 SHALL treat fifo_dout as don't-care whenever fifo_empty=1.

Reset
REQ-024 SHALL while reset=1 force count=0, out_valid=0, out_data=0 and state EMPTY immediately, without waiting for a clock edge.
REQ-025 SHALL hold fifo_r_en=0 while reset=1, and SHALL discard any entries buffered before reset asserts mid-stream.
REQ-026 SHALL resume normal draining on the first posedge after reset deasserts.

Structure
REQ-027 SHALL place the state encoding (EMPTY/ONE/FULL2) and the default WIDTH constant in the shared processor package.
REQ-028 SHALL implement the 2-entry storage as one sub-module, dispatch_skid, which holds the data registers and head/tail select.
REQ-029 SHALL keep fifo_r_en as the only combinational output.

Verification
REQ-030 SHALL verify reset: after asserting reset mid-stream with fifo_empty=0 -> out_valid=0, count=0, fifo_r_en=0 with no clock edge.
REQ-031 SHALL verify streaming: FIFO preloaded with 0x11,0x22,0x33 and out_ready=1 -> out_data shows 0x11,0x22,0x33 on cycles 1,2,3, count=1 each cycle.
REQ-032 SHALL verify backpressure: out_ready=0 with FIFO holding 0xA0,0xA1,0xA2 -> count reaches 2, fifo_r_en=0, 0xA2 stays in the FIFO; after out_ready=1, order is A0,A1,A2.
REQ-033 SHALL verify full with simultaneous push/pop: count=2 and out_ready=1 with fifo_empty=0 -> fifo_r_en=1 and count stays 2.
REQ-034 SHALL verify flush: count=2 and flush=1 with out_ready=1 -> next cycle count=0, out_valid=0, and no FIFO pop occurred that cycle.
REQ-035 SHALL verify empty: fifo_empty=1 throughout -> fifo_r_en=0 and out_valid=0 indefinitely.
